// File: rtl/async_fifo_1clk.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_1clk
// Brief    : Single-clock width-converting FIFO (pack/unpack by power-of-two
//            ratio), FWFT or STANDARD read, optional space counters enabled
//            by macro ASYNC_FIFO_DATA_SPACE_EN.
// Revision : 1.0  initial release
// ============================================================================
module async_fifo_1clk #(
    parameter int    INPUT_WIDTH  = 8,
    parameter int    OUTPUT_WIDTH = 64,
    parameter int    WR_DEPTH     = 128,
    parameter int    RD_DEPTH     = 16,
    parameter string MODE         = "FWFT",
    parameter string DIRECTION    = "MSB"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [INPUT_WIDTH-1:0]          din,
    input  logic                            rd_en,
    output logic                            valid,
    output logic [OUTPUT_WIDTH-1:0]         dout,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(WR_DEPTH):0]       wr_data_count,
    output logic [$clog2(RD_DEPTH):0]       rd_data_count,
    output logic [$clog2(WR_DEPTH):0]       wr_data_space,
    output logic [$clog2(RD_DEPTH):0]       rd_data_space
);

    localparam int c_nw    = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
    localparam int c_wu    = INPUT_WIDTH / c_nw;
    localparam int c_ru    = OUTPUT_WIDTH / c_nw;
    localparam int c_r     = (c_wu > c_ru) ? c_wu : c_ru;
    localparam int c_log2r = $clog2(c_r);
    localparam int c_d     = (WR_DEPTH > RD_DEPTH) ? WR_DEPTH : RD_DEPTH;
    localparam int c_aw    = $clog2(c_d);
    localparam int c_dw    = c_aw + 1;
    localparam int c_wcw   = $clog2(WR_DEPTH) + 1;
    localparam int c_rcw   = $clog2(RD_DEPTH) + 1;

    logic [c_nw-1:0]         r_mem [c_d];
    logic [c_aw-1:0]         r_wr_ptr;
    logic [c_aw-1:0]         r_rd_ptr;
    logic [c_dw-1:0]         r_n;
    logic [c_dw-1:0]         w_n_next;
    logic [c_wcw-1:0]        r_wr_count;
    logic [c_wcw-1:0]        w_wr_count_next;
    logic [c_rcw-1:0]        r_rd_count;
    logic [c_rcw-1:0]        w_rd_count_next;
    logic                    r_full;
    logic                    r_empty;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [OUTPUT_WIDTH-1:0] w_head;

    // Slot i of a wide word maps to this narrow slice index
    function automatic int f_wr_slot(input int i);
        f_wr_slot = (DIRECTION == "MSB") ? (c_wu - 1 - i) : i;
    endfunction

    function automatic int f_rd_slot(input int i);
        f_rd_slot = (DIRECTION == "MSB") ? (c_ru - 1 - i) : i;
    endfunction

    assign w_wr_acc = wr_en && !r_full;
    assign w_rd_acc = rd_en && !r_empty;

    always_comb begin
        w_n_next = r_n;
        if (w_wr_acc) w_n_next = w_n_next + c_dw'(c_wu);
        if (w_rd_acc) w_n_next = w_n_next - c_dw'(c_ru);
    end

    generate
        if (c_wu > 1) begin : g_wr_wide
            // Partially consumed wide word still occupies a write slot
            assign w_wr_count_next = w_n_next[c_dw-1:c_log2r] + c_wcw'(|w_n_next[c_log2r-1:0]);
            assign w_rd_count_next = w_n_next;
        end else begin : g_rd_wide
            assign w_wr_count_next = w_n_next;
            assign w_rd_count_next = w_n_next[c_dw-1:c_log2r];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_n        <= '0;
            r_wr_count <= '0;
            r_rd_count <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_aw'(c_wu);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_aw'(c_ru);
            r_n        <= w_n_next;
            r_wr_count <= w_wr_count_next;
            r_rd_count <= w_rd_count_next;
            r_full     <= (w_wr_count_next == c_wcw'(WR_DEPTH));
            r_empty    <= (w_rd_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < c_wu; i++) begin
                r_mem[r_wr_ptr + c_aw'(i)] <= din[f_wr_slot(i)*c_nw +: c_nw];
            end
        end
    end

    always_comb begin
        w_head = '0;
        for (int i = 0; i < c_ru; i++) begin
            w_head[f_rd_slot(i)*c_nw +: c_nw] = r_mem[r_rd_ptr + c_aw'(i)];
        end
    end

    generate
        if (MODE == "STANDARD") begin : g_standard
            logic                    r_valid;
            logic [OUTPUT_WIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_dout  <= '0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) r_dout <= w_head;
                end
            end
            assign valid = r_valid;
            assign dout  = r_dout;
        end else begin : g_fwft
            // Gate the head so stale memory never shows while empty
            assign valid = !r_empty;
            assign dout  = r_empty ? '0 : w_head;
        end
    endgenerate

`ifdef ASYNC_FIFO_DATA_SPACE_EN
    logic [c_wcw-1:0] r_wr_space;
    logic [c_rcw-1:0] r_rd_space;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_space <= c_wcw'(WR_DEPTH);
            r_rd_space <= c_rcw'(RD_DEPTH);
        end else begin
            r_wr_space <= c_wcw'(WR_DEPTH) - w_wr_count_next;
            r_rd_space <= c_rcw'(RD_DEPTH) - w_rd_count_next;
        end
    end
    assign wr_data_space = r_wr_space;
    assign rd_data_space = r_rd_space;
`else
    assign wr_data_space = '0;
    assign rd_data_space = '0;
`endif

    assign full          = r_full;
    assign empty         = r_empty;
    assign wr_data_count = r_wr_count;
    assign rd_data_count = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_1clk.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_1clk
// Brief    : Directed bench for async_fifo_1clk (pack MSB/LSB, STANDARD, unpack).
// Revision : 1.0  initial release
// ============================================================================
module tb_async_fifo_1clk;

`ifdef ASYNC_FIFO_DATA_SPACE_EN
    localparam bit SPACE_EN = 1'b1;
`else
    localparam bit SPACE_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  din;
    logic        rd_en;
    logic        wr_en_w;
    logic [63:0] din_w;
    logic        rd_en_w;

    logic        a_valid, a_full, a_empty;
    logic [63:0] a_dout;
    logic [7:0]  a_wrc, a_wrs;
    logic [4:0]  a_rdc, a_rds;
    logic        b_valid, b_full, b_empty;
    logic [63:0] b_dout;
    logic [7:0]  b_wrc, b_wrs;
    logic [4:0]  b_rdc, b_rds;
    logic        c_valid, c_full, c_empty;
    logic [63:0] c_dout;
    logic [7:0]  c_wrc, c_wrs;
    logic [4:0]  c_rdc, c_rds;
    logic        d_valid, d_full, d_empty;
    logic [7:0]  d_dout;
    logic [4:0]  d_wrc, d_wrs;
    logic [7:0]  d_rdc, d_rds;

    async_fifo_1clk #(.MODE("FWFT"), .DIRECTION("MSB")) u_msb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .valid(a_valid), .dout(a_dout), .full(a_full), .empty(a_empty),
        .wr_data_count(a_wrc), .rd_data_count(a_rdc),
        .wr_data_space(a_wrs), .rd_data_space(a_rds));

    async_fifo_1clk #(.MODE("FWFT"), .DIRECTION("LSB")) u_lsb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .valid(b_valid), .dout(b_dout), .full(b_full), .empty(b_empty),
        .wr_data_count(b_wrc), .rd_data_count(b_rdc),
        .wr_data_space(b_wrs), .rd_data_space(b_rds));

    async_fifo_1clk #(.MODE("STANDARD"), .DIRECTION("MSB")) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .valid(c_valid), .dout(c_dout), .full(c_full), .empty(c_empty),
        .wr_data_count(c_wrc), .rd_data_count(c_rdc),
        .wr_data_space(c_wrs), .rd_data_space(c_rds));

    async_fifo_1clk #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(8), .WR_DEPTH(16), .RD_DEPTH(128),
                      .MODE("FWFT"), .DIRECTION("MSB")) u_unpack (
        .clk(clk), .rst(rst), .wr_en(wr_en_w), .din(din_w), .rd_en(rd_en_w),
        .valid(d_valid), .dout(d_dout), .full(d_full), .empty(d_empty),
        .wr_data_count(d_wrc), .rd_data_count(d_rdc),
        .wr_data_space(d_wrs), .rd_data_space(d_rds));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_en_w = 1'b0; rd_en_w = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Expected wide word j when the stream is bytes base, base+1, ... (MSB packing)
    function automatic logic [63:0] word_msb(input int base, input int j);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w = {w[55:0], 8'(base + 8*j + k)};
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; din = '0; rd_en = 1'b0; wr_en_w = 1'b0; din_w = '0; rd_en_w = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", a_empty, a_full); end
        checks++; if (a_valid !== 1'b0 || a_dout !== 64'h0) begin failures++; $display("FAIL reset_out valid=%b dout=%h exp 0/0", a_valid, a_dout); end
        checks++; if (a_wrc !== 8'd0 || a_rdc !== 5'd0) begin failures++; $display("FAIL reset_counts wr=%0d rd=%0d exp 0/0", a_wrc, a_rdc); end
        checks++; if (a_wrs !== (SPACE_EN ? 8'd128 : 8'd0) || a_rds !== (SPACE_EN ? 5'd16 : 5'd0)) begin failures++; $display("FAIL reset_space wr=%0d rd=%0d", a_wrs, a_rds); end
        checks++; if (c_valid !== 1'b0 || c_dout !== 64'h0) begin failures++; $display("FAIL reset_std valid=%b dout=%h exp 0/0", c_valid, c_dout); end
        checks++; if (d_empty !== 1'b1 || d_rds !== (SPACE_EN ? 8'd128 : 8'd0)) begin failures++; $display("FAIL reset_unpack empty=%b rds=%0d", d_empty, d_rds); end
    endtask

    task automatic test_pack();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = 8'(i + 1);
            tick();
            if (i == 6) begin
                checks++; if (a_valid !== 1'b0 || a_rdc !== 5'd0 || a_wrc !== 8'd7) begin failures++; $display("FAIL pack_partial valid=%b rd=%0d wr=%0d exp 0/0/7", a_valid, a_rdc, a_wrc); end
            end
        end
        wr_en = 1'b0;
        checks++; if (a_rdc !== 5'd1 || a_wrc !== 8'd8) begin failures++; $display("FAIL pack_counts rd=%0d wr=%0d exp 1/8", a_rdc, a_wrc); end
        checks++; if (a_valid !== 1'b1 || a_dout !== 64'h0102030405060708) begin failures++; $display("FAIL pack_msb valid=%b dout=%h exp 1/0102030405060708", a_valid, a_dout); end
        checks++; if (b_valid !== 1'b1 || b_dout !== 64'h0807060504030201) begin failures++; $display("FAIL pack_lsb valid=%b dout=%h exp 1/0807060504030201", b_valid, b_dout); end
        checks++; if (c_valid !== 1'b0 || c_empty !== 1'b0) begin failures++; $display("FAIL pack_std valid=%b empty=%b exp 0/0", c_valid, c_empty); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            wr_en = 1'b1; din = 8'(i);
            tick();
            if (i == 126) begin
                checks++; if (a_full !== 1'b0 || a_wrc !== 8'd127) begin failures++; $display("FAIL full_early full=%b wr=%0d exp 0/127", a_full, a_wrc); end
            end
        end
        din = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        wr_en = 1'b0;
        checks++; if (a_full !== 1'b1 || a_wrc !== 8'd128 || a_rdc !== 5'd16) begin failures++; $display("FAIL full_counts full=%b wr=%0d rd=%0d exp 1/128/16", a_full, a_wrc, a_rdc); end
        checks++; if (a_wrs !== 8'd0 || a_rds !== 5'd0) begin failures++; $display("FAIL full_space wr=%0d rd=%0d exp 0/0", a_wrs, a_rds); end
        checks++; if (a_dout !== 64'h0001020304050607) begin failures++; $display("FAIL full_head dout=%h exp 0001020304050607", a_dout); end
    endtask

    task automatic test_drain();
        logic [63:0] e;
        rd_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            e = word_msb(0, j);
            checks++; if (a_valid !== 1'b1 || a_dout !== e) begin failures++; $display("FAIL drain_fwft_%0d valid=%b dout=%h exp %h", j, a_valid, a_dout, e); end
            if (j == 3) begin
                checks++; if (b_dout !== 64'h1f1e1d1c1b1a1918) begin failures++; $display("FAIL drain_lsb dout=%h exp 1f1e1d1c1b1a1918", b_dout); end
            end
            tick();
            checks++; if (c_valid !== 1'b1 || c_dout !== e) begin failures++; $display("FAIL drain_std_%0d valid=%b dout=%h exp 1/%h", j, c_valid, c_dout, e); end
            if (j == 0) begin
                checks++; if (a_full !== 1'b0 || a_wrc !== 8'd120 || a_rdc !== 5'd15) begin failures++; $display("FAIL drain_first full=%b wr=%0d rd=%0d exp 0/120/15", a_full, a_wrc, a_rdc); end
            end
        end
        checks++; if (a_empty !== 1'b1 || a_valid !== 1'b0 || a_wrc !== 8'd0 || a_rdc !== 5'd0) begin failures++; $display("FAIL drain_empty empty=%b valid=%b wr=%0d rd=%0d", a_empty, a_valid, a_wrc, a_rdc); end
        checks++; if (a_rds !== (SPACE_EN ? 5'd16 : 5'd0) || a_wrs !== (SPACE_EN ? 8'd128 : 8'd0)) begin failures++; $display("FAIL drain_space wr=%0d rd=%0d", a_wrs, a_rds); end
        tick(); tick();
        rd_en = 1'b0;
        checks++; if (a_empty !== 1'b1 || a_wrc !== 8'd0 || a_rdc !== 5'd0) begin failures++; $display("FAIL drain_extra empty=%b wr=%0d rd=%0d", a_empty, a_wrc, a_rdc); end
        checks++; if (c_valid !== 1'b0 || c_dout !== word_msb(0, 15)) begin failures++; $display("FAIL drain_std_hold valid=%b dout=%h", c_valid, c_dout); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; din = 8'(i);
            tick();
        end
        checks++; if (a_wrc !== 8'd64 || a_rdc !== 5'd8) begin failures++; $display("FAIL b2b_half wr=%0d rd=%0d exp 64/8", a_wrc, a_rdc); end
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 8; k++) begin
                wr_en = 1'b1; din = 8'(64 + 8*g + k); rd_en = (k == 0);
                tick();
                if (k == 0) begin
                    e = word_msb(0, g);
                    checks++; if (c_valid !== 1'b1 || c_dout !== e) begin failures++; $display("FAIL b2b_std_%0d valid=%b dout=%h exp 1/%h", g, c_valid, c_dout, e); end
                    if (g == 0) begin
                        checks++; if (a_wrc !== 8'd57 || a_rdc !== 5'd7) begin failures++; $display("FAIL b2b_net wr=%0d rd=%0d exp 57/7", a_wrc, a_rdc); end
                    end
                end
                if (k == 1) begin
                    checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_%0d valid=%b exp 0", g, c_valid); end
                end
            end
            checks++; if (a_wrc !== 8'd64 || a_rdc !== 5'd8) begin failures++; $display("FAIL b2b_group_%0d wr=%0d rd=%0d exp 64/8", g, a_wrc, a_rdc); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (a_dout !== word_msb(0, 3)) begin failures++; $display("FAIL b2b_head dout=%h exp %h", a_dout, word_msb(0, 3)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; din = 8'(100 + i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (a_wrc !== 8'd32 || c_dout !== word_msb(100, 0)) begin failures++; $display("FAIL mid_pre wr=%0d std=%h", a_wrc, c_dout); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (a_empty !== 1'b1 || a_full !== 1'b0 || a_wrc !== 8'd0 || a_rdc !== 5'd0) begin failures++; $display("FAIL mid_flush empty=%b full=%b wr=%0d rd=%0d", a_empty, a_full, a_wrc, a_rdc); end
        checks++; if (a_valid !== 1'b0 || a_dout !== 64'h0 || c_valid !== 1'b0 || c_dout !== 64'h0) begin failures++; $display("FAIL mid_out a=%b/%h c=%b/%h exp 0", a_valid, a_dout, c_valid, c_dout); end
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = 8'(8'h11 + i);
            tick();
        end
        wr_en = 1'b0;
        checks++; if (a_rdc !== 5'd1 || a_dout !== 64'h1112131415161718) begin failures++; $display("FAIL mid_restart rd=%0d dout=%h exp 1/1112131415161718", a_rdc, a_dout); end
    endtask

    task automatic test_unpack();
        do_reset();
        wr_en_w = 1'b1; din_w = 64'h0102030405060708;
        tick();
        wr_en_w = 1'b0;
        checks++; if (d_wrc !== 5'd1 || d_rdc !== 8'd8 || d_valid !== 1'b1 || d_dout !== 8'h01) begin failures++; $display("FAIL unpack_first wr=%0d rd=%0d valid=%b dout=%h exp 1/8/1/01", d_wrc, d_rdc, d_valid, d_dout); end
        rd_en_w = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++; if (d_dout !== 8'h04 || d_rdc !== 8'd5 || d_wrc !== 5'd1) begin failures++; $display("FAIL unpack_mid dout=%h rd=%0d wr=%0d exp 04/5/1", d_dout, d_rdc, d_wrc); end
        for (int k = 0; k < 5; k++) tick();
        rd_en_w = 1'b0;
        checks++; if (d_empty !== 1'b1 || d_valid !== 1'b0 || d_wrc !== 5'd0) begin failures++; $display("FAIL unpack_empty empty=%b valid=%b wr=%0d", d_empty, d_valid, d_wrc); end
        for (int i = 0; i < 16; i++) begin
            wr_en_w = 1'b1; din_w = {8'(i + 8'h20), 48'h0, 8'(i)};
            tick();
        end
        wr_en_w = 1'b0;
        checks++; if (d_full !== 1'b1 || d_wrc !== 5'd16 || d_rdc !== 8'd128 || d_dout !== 8'h20) begin failures++; $display("FAIL unpack_full full=%b wr=%0d rd=%0d dout=%h exp 1/16/128/20", d_full, d_wrc, d_rdc, d_dout); end
        rd_en_w = 1'b1;
        tick();
        rd_en_w = 1'b0;
        checks++; if (d_full !== 1'b1 || d_wrc !== 5'd16 || d_rdc !== 8'd127 || d_dout !== 8'h00) begin failures++; $display("FAIL unpack_partial full=%b wr=%0d rd=%0d dout=%h exp 1/16/127/00", d_full, d_wrc, d_rdc, d_dout); end
        checks++; if (d_rds !== (SPACE_EN ? 8'd1 : 8'd0) || d_wrs !== 5'd0) begin failures++; $display("FAIL unpack_space wr=%0d rd=%0d", d_wrs, d_rds); end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_full();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_unpack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
